// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB first, repeat_n+1 times, with gap_n idle bit-times between frames.
// Latency: start sampled in IDLE -> MSB on sout the next cycle; all outputs are registered.
// Backpressure: none; start is ignored while busy, and abort cancels the transfer. Define SEQ_TX_PARITY_EN to add an even-parity bit to each frame.
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [CNT_W-1:0] gap_n,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_end,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] MSB_IDX = BIT_W'(PAT_W - 1);

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, GAP, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             frame_last;
    logic             sout_d, valid_d, fe_d, done_d;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        rep_d      = rep_q;
        gap_d      = gap_q;
        gcnt_d     = gcnt_q;
        bit_d      = bit_q;
        frame_last = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SEND;
                    pat_d   = pattern_in;
                    rep_d   = repeat_n;
                    gap_d   = gap_n;
                    bit_d   = MSB_IDX;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_q != '0) begin
                    bit_d = bit_q - 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = PARITY;
`else
                    frame_last = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PARITY: begin
                if (abort) state_d = IDLE;
                else       frame_last = 1'b1;
            end
`endif
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gcnt_q == '0) begin
                    state_d = SEND;
                    bit_d   = MSB_IDX;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // rep_q counts frames still owed after the current one
        if (frame_last) begin
            if (rep_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                rep_d = rep_q - 1'b1;
                bit_d = MSB_IDX;
                if (gap_q != '0) begin
                    state_d = GAP;
                    gcnt_d  = gap_q - 1'b1;
                end else begin
                    state_d = SEND;
                end
            end
        end

        // Outputs are registered alongside the state they describe
`ifdef SEQ_TX_PARITY_EN
        valid_d = (state_d == SEND) || (state_d == PARITY);
        sout_d  = (state_d == SEND)   ? pat_d[bit_d] :
                  (state_d == PARITY) ? ^pat_d       : 1'b0;
        fe_d    = (state_d == PARITY);
`else
        valid_d = (state_d == SEND);
        sout_d  = (state_d == SEND) ? pat_d[bit_d] : 1'b0;
        fe_d    = (state_d == SEND) && (bit_d == '0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            rep_q      <= '0;
            gap_q      <= '0;
            gcnt_q     <= '0;
            bit_q      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            frame_end  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            rep_q      <= rep_d;
            gap_q      <= gap_d;
            gcnt_q     <= gcnt_d;
            bit_q      <= bit_d;
            sout       <= sout_d;
            sout_valid <= valid_d;
            frame_end  <= fe_d;
            done       <= done_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed vector table, hand-written corner sequences, then random stimulus against a queue-based frame model.
module tb_seq_pattern_tx;

    localparam int PAT_W = 4;
    localparam int CNT_W = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk, rst, start, abort;
    logic [PAT_W-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_n, gap_n;
    logic             sout, sout_valid, frame_end, busy, done;

    typedef struct packed {
        logic sout;
        logic valid;
        logic fe;
        logic busy;
        logic done;
    } rec_t;

    typedef struct packed {
        logic             st;
        logic             ab;
        logic [PAT_W-1:0] pat;
        logic [CNT_W-1:0] rep;
        logic [CNT_W-1:0] gap;
        rec_t             exp;
    } vec_t;

    localparam rec_t IDLE_REC = '0;

    rec_t exp_q[$];
    rec_t cur;
    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern_in(pattern_in), .repeat_n(repeat_n), .gap_n(gap_n),
        .sout(sout), .sout_valid(sout_valid), .frame_end(frame_end),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rec(input string tag, input rec_t e);
        chk({tag, ".sout"},       int'(sout),       int'(e.sout));
        chk({tag, ".sout_valid"}, int'(sout_valid), int'(e.valid));
        chk({tag, ".frame_end"},  int'(frame_end),  int'(e.fe));
        chk({tag, ".busy"},       int'(busy),       int'(e.busy));
        chk({tag, ".done"},       int'(done),       int'(e.done));
    endtask

    // Whole transfer expanded into the per-cycle output sequence it should produce
    task automatic build(input logic [PAT_W-1:0] p, input int rep, input int gap);
        rec_t r;
        for (int f = 0; f <= rep; f++) begin
            for (int b = PAT_W - 1; b >= 0; b--) begin
                r = '{sout: p[b], valid: 1'b1, fe: (b == 0) && !PAR, busy: 1'b1, done: 1'b0};
                exp_q.push_back(r);
            end
            if (PAR) begin
                r = '{sout: ^p, valid: 1'b1, fe: 1'b1, busy: 1'b1, done: 1'b0};
                exp_q.push_back(r);
            end
            if (f < rep) begin
                for (int g = 0; g < gap; g++) begin
                    r = '{sout: 1'b0, valid: 1'b0, fe: 1'b0, busy: 1'b1, done: 1'b0};
                    exp_q.push_back(r);
                end
            end
        end
        r = '{sout: 1'b0, valid: 1'b0, fe: 1'b0, busy: 1'b0, done: 1'b1};
        exp_q.push_back(r);
    endtask

    task automatic model_step();
        if (cur.busy && abort) exp_q.delete();
        else if (!cur.busy && start && !abort) build(pattern_in, int'(repeat_n), int'(gap_n));
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_REC;
    endtask

    task automatic drive(input logic st, input logic ab, input logic [PAT_W-1:0] pat,
                         input logic [CNT_W-1:0] rep, input logic [CNT_W-1:0] gap);
        start = st; abort = ab; pattern_in = pat; repeat_n = rep; gap_n = gap;
        model_step();
        @(negedge clk);
    endtask

    task automatic reset_dut(input string tag);
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; pattern_in = '0; repeat_n = '0; gap_n = '0;
        exp_q.delete();
        cur = IDLE_REC;
        repeat (2) @(negedge clk);
        chk_rec(tag, IDLE_REC);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic st, input logic ab, input logic [PAT_W-1:0] pat,
                                input logic [CNT_W-1:0] rep, input logic [CNT_W-1:0] gap,
                                input logic s, input logic v, input logic f, input logic b, input logic d);
        vec_t t;
        t.st = st; t.ab = ab; t.pat = pat; t.rep = rep; t.gap = gap;
        t.exp = '{sout: s, valid: v, fe: f, busy: b, done: d};
        return t;
    endfunction

    initial begin
        logic [11:0] bits;
        int          nv, nfe, nd;

`ifdef SEQ_TX_PARITY_EN
        // parity on: 1101 -> 1,1,0,1 then parity 1 with frame_end
        tbl.push_back(mk(1, 0, 4'b1101, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
`else
        // single frame 1101
        tbl.push_back(mk(1, 0, 4'b1101, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        // two frames with a 2-cycle gap
        tbl.push_back(mk(1, 0, 4'b1101, 1, 2, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        // abort while the 2nd bit is out, then a full 1011 frame
        tbl.push_back(mk(1, 0, 4'b1101, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'b1011, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
        // start held mid-transfer with a new pattern is ignored; start in done cycle is taken
        tbl.push_back(mk(1, 0, 4'b1101, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 4'b0110, 3, 3, 1, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 4'b0110, 3, 3, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 4'b0110, 3, 3, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'b0110, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
`endif

        reset_dut("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].ab, tbl[i].pat, tbl[i].rep, tbl[i].gap);
            chk_rec($sformatf("vec%0d", i), tbl[i].exp);
        end

`ifndef SEQ_TX_PARITY_EN
        // three back-to-back frames with no gap
        reset_dut("reset2");
        bits = '0; nv = 0; nfe = 0; nd = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 0) drive(1, 0, 4'b1101, 2, 0);
            else        drive(0, 0, 4'b0000, 0, 0);
            bits = {bits[10:0], sout};
            nv  += int'(sout_valid);
            nfe += int'(frame_end);
            nd  += int'(done);
        end
        drive(0, 0, 4'b0000, 0, 0);
        chk("b2b.done_cycle", int'(done), 1);
        nd += int'(done);
        drive(0, 0, 4'b0000, 0, 0);
        nd += int'(done);
        chk("b2b.bits", int'(bits), int'(12'b110111011101));
        chk("b2b.valid_cnt", nv, 12);
        chk("b2b.fe_cnt", nfe, 3);
        chk("b2b.done_cnt", nd, 1);
`endif

        // asynchronous reset in the middle of a transfer
        drive(1, 0, 4'b1111, 3, 1);
        drive(0, 0, 4'b0000, 0, 0);
        #2 rst = 1'b1;
        #1 chk_rec("async_rst", IDLE_REC);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        cur = IDLE_REC;
        drive(0, 0, 4'b0000, 0, 0);
        chk_rec("post_rst", IDLE_REC);

        // random traffic against the frame model, including all-ones counts
        reset_dut("reset3");
        for (int c = 0; c < 5000; c++) begin
            drive(($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 59) == 0),
                  PAT_W'($urandom),
                  ($urandom_range(0, 7) == 0) ? '1 : CNT_W'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0) ? '1 : CNT_W'($urandom_range(0, 2)));
            chk_rec($sformatf("rand%0d", c), cur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning pattern width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, meaning width of the repeat and gap counters.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to transmit; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of the current transfer.
REQ-007 SHALL have port pattern_in, input, PAT_W, pattern to send, MSB first.
REQ-008 SHALL have port repeat_n, input, CNT_W, frame count minus one.
REQ-009 SHALL have port gap_n, input, CNT_W, idle bit-times between frames.
REQ-010 SHALL have port sout, output, 1, registered serial data.
REQ-011 SHALL have port sout_valid, output, 1, registered qualifier for sout.
REQ-012 SHALL have port frame_end, output, 1, high with the last bit of each frame.
REQ-013 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, SEND, GAP, plus PARITY when SEQ_TX_PARITY_EN is defined.
REQ-016 SHALL, on start=1 in IDLE, capture pattern_in, repeat_n and gap_n into internal registers and enter SEND at the next edge.
REQ-017 SHALL present the first pattern bit (MSB) on sout with sout_valid=1 in the first SEND cycle, then one bit per cycle.
REQ-018 SHALL ignore changes on pattern_in, repeat_n and gap_n after capture.
REQ-019 SHALL send repeat_n+1 frames in total; repeat_n=0 sends one frame.
REQ-020 SHALL, after the final bit of a frame with frames remaining, go to GAP if captured gap_n>0, otherwise start the next frame's MSB in the immediately following cycle.
REQ-021 SHALL hold sout=0 and sout_valid=0 for exactly gap_n cycles in GAP, then return to SEND.
REQ-022 SHALL assert frame_end together with the final bit of every frame (the parity bit when parity is enabled).
REQ-023 SHALL, after the final bit of the last frame, enter IDLE and assert done=1 for exactly that first IDLE cycle, with sout_valid=0.
REQ-024 SHALL accept start in the done cycle; the next transfer's MSB then appears one cycle later.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, on abort=1 in any non-IDLE state, enter IDLE at the next edge with sout_valid=0 and no done pulse; abort has priority over start.
REQ-027 SHALL drive sout=0 whenever sout_valid=0.
REQ-028 SHALL keep all counters at CNT_W bits; repeat_n and gap_n at all-ones SHALL be honoured without wrap errors.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, sout=0, sout_valid=0, frame_end=0, busy=0, done=0, and clear all counters and capture registers.
REQ-030 SHALL, on rst asserted mid-transfer, abandon the transfer immediately with no done pulse.

Configuration
REQ-031 SHALL, when SEQ_TX_PARITY_EN is defined, append one even-parity bit (XOR of the captured pattern) after the LSB of every frame, giving a frame length of PAT_W+1.
REQ-032 SHALL, when SEQ_TX_PARITY_EN is not defined, omit the PARITY state, giving a frame length of PAT_W.

Verification
REQ-033 SHALL check: pattern 1101, repeat 0, gap 0, parity off -> sout 1,1,0,1 with valid on 4 cycles, frame_end on 4th bit, done on the 5th cycle.
REQ-034 SHALL check: pattern 1101, repeat 2, gap 0 -> 12 contiguous valid bits 110111011101, three frame_end pulses, one done.
REQ-035 SHALL check: pattern 1101, repeat 1, gap 2 -> 1101, two cycles valid=0/sout=0, 1101, done.
REQ-036 SHALL check: abort after the 2nd bit -> valid low next cycle, busy low, no done; a subsequent start sends a full frame.
REQ-037 SHALL check: start pulsed mid-transfer -> ignored; start in the done cycle -> new MSB the next cycle.
REQ-038 SHALL check: parity on, pattern 1101 -> sout 1,1,0,1,1 with frame_end on the 5th bit.
